// File: rtl/voice_envelope_mixer.sv
// Scales a time-multiplexed stream of voice samples by clamped ADSR envelopes and
// either mixes each frame into one saturated sample or passes every scaled voice through.
module voice_envelope_mixer #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ENVELOPE_WIDTH = 16,
   parameter int unsigned NUM_VOICES     = 4,
   parameter int unsigned SUM_SHIFT      = 2
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 mix_mode,
   input  logic                                                 s_valid,
   output logic                                                 s_ready,
   input  logic signed [DATA_WIDTH-1:0]                         s_audio,
   input  logic        [ENVELOPE_WIDTH-1:0]                     s_envelope,
   output logic                                                 m_valid,
   input  logic                                                 m_ready,
   output logic signed [DATA_WIDTH-1:0]                         m_data,
   output logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] m_voice,
   output logic                                                 m_sat
);

   localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned PW = DATA_WIDTH + ENVELOPE_WIDTH + 1;
   localparam int unsigned SW = DATA_WIDTH + 1;
   localparam int unsigned AW = DATA_WIDTH + $clog2(NUM_VOICES) + 1;

   localparam logic [ENVELOPE_WIDTH-1:0] ENV_ONE  = {1'b1, {(ENVELOPE_WIDTH-1){1'b0}}};
   localparam logic signed [AW-1:0]      SAT_MAX  = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0]      SAT_MIN  = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [VW-1:0]             LAST_IDX = VW'(NUM_VOICES - 1);

   // Clamp to the signed output range; MSB of the result flags a clamp.
   function automatic logic [DATA_WIDTH:0] saturate(input logic signed [AW-1:0] x);
      if (x > SAT_MAX)
         return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (x < SAT_MIN)
         return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         return {1'b0, x[DATA_WIDTH-1:0]};
   endfunction

   logic                          en;
   logic                          accept;
   logic [VW-1:0]                 vcnt;
   logic                          frame_mode;
   logic                          first_c;
   logic                          last_c;
   logic                          mode_c;
   logic [ENVELOPE_WIDTH-1:0]     env_c;
   logic signed [PW-1:0]          product_c;
   logic signed [SW-1:0]          scaled_c;

   logic                          s1_valid;
   logic                          s1_first;
   logic                          s1_last;
   logic                          s1_mode;
   logic [VW-1:0]                 s1_voice;
   logic signed [SW-1:0]          s1_scaled;

   logic signed [AW-1:0]          acc;
   logic signed [AW-1:0]          acc_next_c;
   logic signed [AW-1:0]          mix_sum_c;
   logic [DATA_WIDTH:0]           sat_c;

   assign en      = !m_valid || m_ready;
   assign s_ready = en;
   assign accept  = s_valid && en;

   // Stage-1 datapath: envelope clamp, signed multiply, Q1 rescale.
   always_comb begin
      first_c   = (vcnt == '0);
      last_c    = (vcnt == LAST_IDX);
      mode_c    = first_c ? mix_mode : frame_mode;
      env_c     = (s_envelope > ENV_ONE) ? ENV_ONE : s_envelope;
      product_c = PW'(s_audio) * PW'($signed({1'b0, env_c}));
      scaled_c  = SW'(product_c >>> (ENVELOPE_WIDTH - 1));
   end

   // Stage-2 datapath: frame accumulation and output saturation.
   always_comb begin
      acc_next_c = (s1_first ? '0 : acc) + AW'(s1_scaled);
      mix_sum_c  = acc_next_c >>> SUM_SHIFT;
      sat_c      = s1_mode ? saturate(mix_sum_c) : saturate(AW'(s1_scaled));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vcnt       <= '0;
         frame_mode <= 1'b0;
         s1_valid   <= 1'b0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
         s1_mode    <= 1'b0;
         s1_voice   <= '0;
         s1_scaled  <= '0;
         acc        <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_voice    <= '0;
         m_sat      <= 1'b0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            vcnt      <= last_c ? '0 : vcnt + VW'(1);
            s1_first  <= first_c;
            s1_last   <= last_c;
            s1_mode   <= mode_c;
            s1_voice  <= vcnt;
            s1_scaled <= scaled_c;
            if (first_c)
               frame_mode <= mix_mode;
         end

         m_valid <= 1'b0;
         if (s1_valid) begin
            if (s1_mode) begin
               acc <= acc_next_c;
               if (s1_last) begin
                  m_valid <= 1'b1;
                  m_data  <= sat_c[DATA_WIDTH-1:0];
                  m_voice <= LAST_IDX;
                  m_sat   <= sat_c[DATA_WIDTH];
               end
            end else begin
               m_valid <= 1'b1;
               m_data  <= sat_c[DATA_WIDTH-1:0];
               m_voice <= s1_voice;
               m_sat   <= sat_c[DATA_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_voice_envelope_mixer.sv
// Directed bench for voice_envelope_mixer: two instances (SUM_SHIFT 2 and 0) share one stimulus stream.
module tb_voice_envelope_mixer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               mix_mode;
   logic               s_valid;
   logic signed [15:0] s_audio;
   logic [15:0]        s_envelope;
   logic               m_ready;

   logic               s_ready2, m_valid2, m_sat2;
   logic signed [15:0] m_data2;
   logic [1:0]         m_voice2;
   logic               s_ready0, m_valid0, m_sat0;
   logic signed [15:0] m_data0;
   logic [1:0]         m_voice0;

   typedef struct {
      int data;
      int voice;
      int sat;
      int cyc;
   } out_t;

   out_t q2[$];
   out_t q0[$];
   int   acc_q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_checks = 0;

   always #5 clk = ~clk;

   voice_envelope_mixer #(.DATA_WIDTH(16), .ENVELOPE_WIDTH(16), .NUM_VOICES(4), .SUM_SHIFT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mix_mode(mix_mode), .s_valid(s_valid), .s_ready(s_ready2),
      .s_audio(s_audio), .s_envelope(s_envelope), .m_valid(m_valid2), .m_ready(m_ready),
      .m_data(m_data2), .m_voice(m_voice2), .m_sat(m_sat2));

   voice_envelope_mixer #(.DATA_WIDTH(16), .ENVELOPE_WIDTH(16), .NUM_VOICES(4), .SUM_SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mix_mode(mix_mode), .s_valid(s_valid), .s_ready(s_ready0),
      .s_audio(s_audio), .s_envelope(s_envelope), .m_valid(m_valid0), .m_ready(m_ready),
      .m_data(m_data0), .m_voice(m_voice0), .m_sat(m_sat0));

   // Record accepts and output handshakes mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && s_valid && s_ready2) acc_q.push_back(cyc);
      if (rst_n && m_valid2 && m_ready)
         q2.push_back('{int'(m_data2), int'(m_voice2), int'(m_sat2), cyc});
      if (rst_n && m_valid0 && m_ready)
         q0.push_back('{int'(m_data0), int'(m_voice0), int'(m_sat0), cyc});
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      tick(n);
   endtask

   // Present one beat and return once it has been accepted (bounded wait).
   task automatic send(input int a, input int e, input bit mode);
      int guard = 0;
      s_valid    = 1'b1;
      s_audio    = 16'(a);
      s_envelope = 16'(e);
      mix_mode   = mode;
      @(negedge clk);
      while (!s_ready2 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("send_timeout", guard, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input bit use0, input string tag, input int d, input int v,
                             input int s, output int ocyc);
      out_t o;
      int   sz;
      sz   = use0 ? q0.size() : q2.size();
      ocyc = -1;
      check({tag, "_present"}, (sz > 0) ? 1 : 0, 1);
      if (sz > 0) begin
         o    = use0 ? q0.pop_front() : q2.pop_front();
         ocyc = o.cyc;
         check({tag, "_data"}, o.data, d);
         check({tag, "_voice"}, o.voice, v);
         check({tag, "_sat"}, o.sat, s);
      end
   endtask

   task automatic clear_q();
      q2.delete();
      q0.delete();
      acc_q.delete();
   endtask

   initial begin
      int pa[4] = '{1000, -1000, 32767, -32768};
      int pe[4] = '{16384, 32768, 32768, 16384};
      int pd[4] = '{500, -1000, 32767, -16384};
      int ca[4] = '{2000, 2000, -2000, 2000};
      int ce[4] = '{65535, 0, 65535, 32769};
      int cd[4] = '{2000, 0, -2000, 2000};
      int oc;
      int ac;

      rst_n = 1'b0; s_valid = 1'b0; s_audio = '0; s_envelope = '0; mix_mode = 1'b0; m_ready = 1'b1;
      tick(3);
      check("rst_m_valid", int'(m_valid2), 0);
      check("rst_m_data", int'(m_data2), 0);
      check("rst_m_voice", int'(m_voice2), 0);
      check("rst_m_sat", int'(m_sat2), 0);
      check("rst_s_ready", int'(s_ready2), 1);
      rst_n = 1'b1;
      tick(1);
      clear_q();

      // Passthrough with latency
      for (int i = 0; i < 4; i++) send(pa[i], pe[i], 1'b0);
      idle(6);
      for (int i = 0; i < 4; i++) begin
         expect_out(1'b0, $sformatf("pass%0d", i), pd[i], i, 0, oc);
         ac = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
         check($sformatf("pass%0d_latency", i), oc - ac, 2);
      end
      check("pass_extra", q2.size(), 0);
      clear_q();

      // Envelope clamp
      for (int i = 0; i < 4; i++) send(ca[i], ce[i], 1'b0);
      idle(6);
      for (int i = 0; i < 4; i++) expect_out(1'b0, $sformatf("clamp%0d", i), cd[i], i, 0, oc);
      check("clamp_extra", q2.size(), 0);
      clear_q();

      // Mix: full-scale positive then negative frames
      for (int i = 0; i < 4; i++) send(32767, 32768, 1'b1);
      for (int i = 0; i < 4; i++) send(-32768, 32768, 1'b1);
      idle(6);
      expect_out(1'b0, "mix_pos", 32767, 3, 0, oc);
      expect_out(1'b0, "mix_neg", -32768, 3, 0, oc);
      expect_out(1'b1, "mix0_pos", 32767, 3, 1, oc);
      expect_out(1'b1, "mix0_neg", -32768, 3, 1, oc);
      check("mix_extra", q2.size(), 0);
      clear_q();

      // Mix saturation (shift 0) followed by a clean frame
      for (int i = 0; i < 4; i++) send(20000, 32768, 1'b1);
      for (int i = 0; i < 4; i++) send(100, 32768, 1'b1);
      idle(6);
      expect_out(1'b1, "sat0_hi", 32767, 3, 1, oc);
      expect_out(1'b1, "sat0_clean", 400, 3, 0, oc);
      expect_out(1'b0, "sat2_hi", 20000, 3, 0, oc);
      expect_out(1'b0, "sat2_clean", 100, 3, 0, oc);
      check("sat_extra", q0.size(), 0);
      clear_q();

      // Backpressure in passthrough
      fork
         begin
            for (int i = 0; i < 8; i++) send(10 * (i + 1), 32768, 1'b0);
            idle(1);
         end
         begin
            m_ready = 1'b0;
            tick(6);
            check("bp_s_ready", int'(s_ready2), 0);
            check("bp_m_valid", int'(m_valid2), 1);
            for (int j = 0; j < 10; j++) begin
               m_ready = j[0];
               tick(1);
            end
            m_ready = 1'b1;
         end
      join
      idle(8);
      for (int i = 0; i < 8; i++) expect_out(1'b0, $sformatf("bp%0d", i), 10 * (i + 1), i % 4, 0, oc);
      check("bp_extra", q2.size(), 0);
      clear_q();

      // Reset mid-frame while an output is stalled
      m_ready = 1'b0;
      send(123, 32768, 1'b0);
      send(456, 32768, 1'b0);
      s_valid = 1'b0;
      check("pre_rst_valid", int'(m_valid2), 1);
      check("pre_rst_data", int'(m_data2), 123);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(m_valid2), 0);
      check("mid_rst_data", int'(m_data2), 0);
      check("mid_rst_voice", int'(m_voice2), 0);
      check("mid_rst_sat", int'(m_sat2), 0);
      m_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      clear_q();
      for (int i = 0; i < 4; i++) send(400, 32768, 1'b1);
      idle(6);
      expect_out(1'b0, "post_rst_mix", 400, 3, 0, oc);
      expect_out(1'b1, "post_rst_mix0", 1600, 3, 0, oc);
      check("post_rst_extra", q2.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
